// File: rtl/cmp_sweeper.sv
// Drives every {A,B} operand pair into the comparator, counts Out=1 hits and latches the first hit.
// One pair per clock, sweep takes 2^(2W)+1 cycles; no backpressure, start is ignored unless idle.
module cmp_sweeper #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [W-1:0]   A,
  output logic [W-1:0]   B,
  input  logic           cmp_out,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   hit_cnt,
  output logic           hit_valid,
  output logic [2*W-1:0] first_hit
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_pair;
  assign last_pair = (A == {W{1'b1}}) && (B == {W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (last_pair) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SWEEP:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // {A,B} as one counter gives A-outer/B-inner order and wraps to 0 after the last pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      A         <= '0;
      B         <= '0;
      hit_cnt   <= '0;
      hit_valid <= 1'b0;
      first_hit <= '0;
    end else begin
      case (state)
        IDLE: begin
          A <= '0;
          B <= '0;
          if (start) begin
            hit_cnt   <= '0;
            hit_valid <= 1'b0;
            first_hit <= '0;
          end
        end
        SWEEP: begin
          {A, B} <= {A, B} + (2*W)'(1);
          if (cmp_out) begin
            hit_cnt <= hit_cnt + (2*W+1)'(1);
            if (!hit_valid) begin
              first_hit <= {A, B};
              hit_valid <= 1'b1;
            end
          end
        end
        default: begin
          A <= '0;
          B <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sweeper.sv
// Bench for cmp_sweeper: a comparator model closes the loop, a scoreboard holds the expected pair order and results.
module tb_cmp_sweeper;
  localparam int W  = 4;
  localparam int NP = 1 << (2*W);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           cmp_out;
  logic           busy;
  logic           done;
  logic [2*W:0]   hit_cnt;
  logic           hit_valid;
  logic [2*W-1:0] first_hit;

  int   mode = 0;
  logic rnd_bit = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct packed {
    logic [2*W:0]   cnt;
    logic           vld;
    logic [2*W-1:0] first;
  } res_t;

  logic [2*W-1:0] pair_q[$];
  res_t           res_q[$];
  res_t           last_res;

  always #5 clk = ~clk;

  // comparator stand-in: 0 = tied low, 1 = A>B, 2 = A==B, 3 = tied high, 4 = random
  always_comb begin
    case (mode)
      1:       cmp_out = (A > B);
      2:       cmp_out = (A == B);
      3:       cmp_out = 1'b1;
      4:       cmp_out = rnd_bit;
      default: cmp_out = 1'b0;
    endcase
  end

  cmp_sweeper #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .cmp_out   (cmp_out),
    .busy      (busy),
    .done      (done),
    .hit_cnt   (hit_cnt),
    .hit_valid (hit_valid),
    .first_hit (first_hit)
  );

  function automatic logic model_hit(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    case (m)
      1:       return a > b;
      2:       return a == b;
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_expected();
    res_t r;
    logic [2*W-1:0] p;
    r = '0;
    for (int k = 0; k < NP; k++) begin
      p = k[2*W-1:0];
      pair_q.push_back(p);
      if (model_hit(mode, p[2*W-1:W], p[W-1:0])) begin
        r.cnt = r.cnt + 1'b1;
        if (!r.vld) begin
          r.first = p;
          r.vld   = 1'b1;
        end
      end
    end
    res_q.push_back(r);
  endtask

  // inject_at: pair index during which start is re-pulsed (-1 none); reset_at: pair index to reset at (-1 none)
  task automatic run_sweep(input int inject_at, input int reset_at);
    res_t r;
    logic [2*W-1:0] p;
    int dones;
    dones = 0;
    @(negedge clk);
    pair_q.delete();
    res_q.delete();
    push_expected();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= NP + 2; c++) begin
      @(negedge clk);
      start = (inject_at >= 0) && (c == inject_at + 1);
      if (done) dones++;
      if (c <= NP) begin
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL sweep_flags c=%0d busy=%b done=%b required busy=1 done=0", c, busy, done);
        end
        n_cmp++;
        if (pair_q.size() == 0) begin
          n_err++;
          $display("FAIL pair_order c=%0d scoreboard empty, got %h", c, {A, B});
        end else begin
          p = pair_q.pop_front();
          if ({A, B} !== p) begin
            n_err++;
            $display("FAIL pair_order c=%0d got %h required %h", c, {A, B}, p);
          end
        end
      end
      if (reset_at >= 0 && c == reset_at + 1) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({A, B, busy, done, hit_cnt, hit_valid, first_hit} !== '0) begin
          n_err++;
          $display("FAIL mid_reset A=%h B=%h busy=%b done=%b cnt=%h vld=%b first=%h required all 0",
                   A, B, busy, done, hit_cnt, hit_valid, first_hit);
        end
        @(negedge clk);
        n_cmp++;
        if ({A, B, busy, done} !== '0) begin
          n_err++;
          $display("FAIL after_reset_idle A=%h B=%h busy=%b done=%b required 0", A, B, busy, done);
        end
        pair_q.delete();
        res_q.delete();
        return;
      end
      if (c == NP + 1) begin
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || {A, B} !== '0) begin
          n_err++;
          $display("FAIL done_cycle done=%b busy=%b AB=%h required done=1 busy=0 AB=00", done, busy, {A, B});
        end
        n_cmp++;
        if (res_q.size() == 0) begin
          n_err++;
          $display("FAIL result scoreboard empty");
        end else begin
          r = res_q.pop_front();
          last_res = r;
          if (hit_cnt !== r.cnt || hit_valid !== r.vld || first_hit !== r.first) begin
            n_err++;
            $display("FAIL result cnt=%h vld=%b first=%h required cnt=%h vld=%b first=%h",
                     hit_cnt, hit_valid, first_hit, r.cnt, r.vld, r.first);
          end
        end
      end
      if (c == NP + 2) begin
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL back_to_idle done=%b busy=%b required 0 0", done, busy);
        end
      end
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL done_pulses got %0d required 1", dones);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({A, B, busy, done, hit_cnt, hit_valid, first_hit} !== '0) begin
      n_err++;
      $display("FAIL reset_state A=%h B=%h busy=%b done=%b cnt=%h vld=%b first=%h required all 0",
               A, B, busy, done, hit_cnt, hit_valid, first_hit);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({A, B, busy, done} !== '0) begin
        n_err++;
        $display("FAIL idle_hold i=%0d A=%h B=%h busy=%b done=%b required 0", i, A, B, busy, done);
      end
    end
  endtask

  task automatic test_tied_zero();
    mode = 0;
    run_sweep(-1, -1);
  endtask

  task automatic test_greater();
    mode = 1;
    run_sweep(-1, -1);
    n_cmp++;
    if (hit_cnt !== 9'd120 || first_hit !== 8'h10 || hit_valid !== 1'b1) begin
      n_err++;
      $display("FAIL gt_totals cnt=%0d first=%h vld=%b required 120 10 1", hit_cnt, first_hit, hit_valid);
    end
  endtask

  task automatic test_equal_and_all();
    mode = 2;
    run_sweep(-1, -1);
    n_cmp++;
    if (hit_cnt !== 9'd16 || first_hit !== 8'h00) begin
      n_err++;
      $display("FAIL eq_totals cnt=%0d first=%h required 16 00", hit_cnt, first_hit);
    end
    mode = 3;
    run_sweep(-1, -1);
    n_cmp++;
    if (hit_cnt !== 9'h100 || first_hit !== 8'h00) begin
      n_err++;
      $display("FAIL all_totals cnt=%h first=%h required 100 00", hit_cnt, first_hit);
    end
  endtask

  task automatic test_start_ignored_and_hold();
    mode = 1;
    run_sweep(50, -1);
    mode = 4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rnd_bit = 1'($urandom_range(0, 1));
      n_cmp++;
      if (hit_cnt !== last_res.cnt || hit_valid !== last_res.vld || first_hit !== last_res.first ||
          {A, B, busy, done} !== '0) begin
        n_err++;
        $display("FAIL result_hold i=%0d cnt=%h vld=%b first=%h AB=%h busy=%b done=%b required cnt=%h vld=%b first=%h idle",
                 i, hit_cnt, hit_valid, first_hit, {A, B}, busy, done, last_res.cnt, last_res.vld, last_res.first);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    mode = 2;
    run_sweep(-1, 100);
    mode = 1;
    run_sweep(-1, -1);
  endtask

  initial begin
    test_reset();
    test_tied_zero();
    test_greater();
    test_equal_and_all();
    test_start_ignored_and_hold();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
